// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the load/store unit: RISC-V funct3 size codes,
// the handshake FSM state type, and a helper that tells how many bits a
// load brings back before it is extended to the full word.
package dmem_pkg;

    // RISC-V funct3 codes for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Handshake FSM states
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Width in bits of the loaded value before sign/zero extension
    function automatic logic [5:0] loadWidth(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: loadWidth = 6'd8;
            F3_H, F3_HU: loadWidth = 6'd16;
            default:     loadWidth = 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ls_align.sv
// dmem_ls_align
// Combinational lane logic for RV32 sub-word accesses.
// Ports:
//   funct3    in   size/sign code of the access
//   we        in   1 = store (unsigned sizes are illegal for stores)
//   addrLow   in   byte offset within the word, a[1:0]
//   wd        in   right-aligned store data
//   rawWord   in   word read from the array
//   byteEn    out  byte lanes to write (all zero on a faulting access)
//   wdata     out  store data replicated onto every lane
//   loadData  out  selected lane, sign- or zero-extended to 32 bits
//   misalign  out  misaligned half/word access (trap build only)
//   illegal   out  funct3 not valid for this direction
// Build option: DMEM_MISALIGN_TRAP_EN flags misaligned accesses; without
// it, the low address bits are forced to natural alignment.
module dmem_ls_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  addrLow,
    input  logic [31:0] wd,
    input  logic [31:0] rawWord,
    output logic [3:0]  byteEn,
    output logic [31:0] wdata,
    output logic [31:0] loadData,
    output logic        misalign,
    output logic        illegal
);

    logic [1:0]  offset;
    logic [31:0] shifted;
    logic [5:0]  width;
    logic        signExt;

    // Classify the access and work out the effective byte offset. Without
    // the trap option, halfword and word offsets are rounded down so that
    // the access stays inside its natural container.
    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        offset   = addrLow;
        case (funct3)
            F3_B, F3_BU: offset = addrLow;
            F3_H, F3_HU: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                misalign = addrLow[0];
`else
                offset = {addrLow[1], 1'b0};
`endif
            end
            F3_W: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                misalign = (addrLow != 2'b00);
`else
                offset = 2'b00;
`endif
            end
            default: illegal = 1'b1;
        endcase
        if (we && funct3[2]) begin
            illegal = 1'b1;
        end
    end

    // Store path: replicate the data on all lanes and let the byte enables
    // pick which lanes land. A faulting access enables nothing.
    always_comb begin
        byteEn = 4'b0000;
        wdata  = wd;
        if (!illegal && !misalign) begin
            case (funct3[1:0])
                2'b00: begin
                    byteEn = 4'b0001 << offset;
                    wdata  = {4{wd[7:0]}};
                end
                2'b01: begin
                    byteEn = 4'b0011 << offset;
                    wdata  = {2{wd[15:0]}};
                end
                default: byteEn = 4'b1111;
            endcase
        end
    end

    // Load path: bring the addressed lane down to bit 0, then extend.
    // Codes with funct3[2]=0 are the signed loads.
    always_comb begin
        shifted = rawWord >> {offset, 3'b000};
        width   = loadWidth(funct3);
        signExt = ~funct3[2];
        case (width)
            6'd8:    loadData = {{24{signExt & shifted[7]}}, shifted[7:0]};
            6'd16:   loadData = {{16{signExt & shifted[15]}}, shifted[15:0]};
            default: loadData = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu
// Word-organised data memory with RISC-V sub-word loads/stores and a
// req/ready handshake with WAIT_STATES extra cycles before the access.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   req     in   request strobe, only looked at in IDLE
//   we      in   1 = store, 0 = load
//   funct3  in   RISC-V size/sign code
//   a       in   byte address (wraps modulo DEPTH*4)
//   wd      in   right-aligned store data
//   rd      out  load result (0 for stores and faults), held until next RESP
//   ready   out  one-cycle completion pulse
//   busy    out  high from acceptance until ready
//   err     out  error flag, valid with ready
// Build option: DMEM_MISALIGN_TRAP_EN (see dmem_ls_align).
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int IDX_HI = IDX_W + 1;
    localparam int CNT_W  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t             state;
    state_t             nextState;
    logic [CNT_W-1:0]   count;
    logic [IDX_HI:0]    aReg;
    logic               weReg;
    logic [31:0]        wdReg;
    logic [2:0]         f3Reg;
    logic [31:0]        rdReg;
    logic               errReg;
    logic [31:0]        mem [DEPTH];

    logic [IDX_HI:0]    opA;
    logic               opWe;
    logic [31:0]        opWd;
    logic [2:0]         opF3;
    logic [IDX_W-1:0]   wordIdx;
    logic [31:0]        rawWord;
    logic [3:0]         byteEn;
    logic [31:0]        wdata;
    logic [31:0]        loadData;
    logic               misalign;
    logic               illegal;
    logic               fault;
    logic               enterResp;
    logic               unusedAddrBits;

    // Address bits above the array size are ignored, which gives the wrap.
    assign unusedAddrBits = ^a[ADDR_W-1:IDX_HI+1];

    // With zero wait states the access happens on the accepting edge, so
    // the operands come straight from the inputs while still in IDLE.
    assign opA     = (state == IDLE) ? a[IDX_HI:0] : aReg;
    assign opWe    = (state == IDLE) ? we : weReg;
    assign opWd    = (state == IDLE) ? wd : wdReg;
    assign opF3    = (state == IDLE) ? funct3 : f3Reg;
    assign wordIdx = opA[IDX_HI:2];
    assign rawWord = mem[wordIdx];
    assign fault   = illegal | misalign;

    dmem_ls_align u_align (
        .funct3   (opF3),
        .we       (opWe),
        .addrLow  (opA[1:0]),
        .wd       (opWd),
        .rawWord  (rawWord),
        .byteEn   (byteEn),
        .wdata    (wdata),
        .loadData (loadData),
        .misalign (misalign),
        .illegal  (illegal)
    );

    // Next-state logic for the IDLE -> WAIT -> RESP handshake.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (req) nextState = (WAIT_STATES == 0) ? RESP : WAIT;
            WAIT:    if (count == '0) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign enterResp = (nextState == RESP) && (state != RESP);

    // State, wait counter, latched request and the registered response.
    // Reset wins over everything, which is what aborts an access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            aReg   <= '0;
            weReg  <= 1'b0;
            wdReg  <= '0;
            f3Reg  <= '0;
            rdReg  <= '0;
            errReg <= 1'b0;
        end else begin
            state <= nextState;
            if (state == IDLE && req) begin
                aReg  <= a[IDX_HI:0];
                weReg <= we;
                wdReg <= wd;
                f3Reg <= funct3;
                count <= CNT_INIT;
            end else if (state == WAIT && count != '0) begin
                count <= count - 1'b1;
            end
            if (enterResp) begin
                errReg <= fault;
                rdReg  <= (opWe || fault) ? 32'd0 : loadData;
            end
        end
    end

    // Byte-lane writes on the edge entering RESP; untouched lanes keep
    // their old contents. The array itself has no reset.
    always_ff @(posedge clk) begin
        if (!rst && enterResp && opWe) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    mem[wordIdx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rd    = rdReg;
    assign err   = errReg;
    assign ready = (state == RESP);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu
// Drives three dmem_lsu instances (WAIT_STATES = 0, 1, 3) with the same
// operations and compares them against a byte-level reference memory.
// Honours DMEM_MISALIGN_TRAP_EN the same way the design does.
module tb_dmem_lsu;
    import dmem_pkg::*;

    localparam int DEPTH = 64;
    localparam int NDUT  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NDUT-1:0] req;
    logic            we;
    logic [2:0]      funct3;
    logic [31:0]     a;
    logic [31:0]     wd;
    logic [31:0]     rdV [NDUT];
    logic [NDUT-1:0] readyV;
    logic [NDUT-1:0] busyV;
    logic [NDUT-1:0] errV;

    int nCompared   = 0;
    int nMismatched = 0;
    int opNum       = 0;

    logic [7:0] refMem [DEPTH*4];

    always #5 clk = ~clk;

    function automatic int wsOf(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        dmem_lsu #(
            .DATA_W      (32),
            .ADDR_W      (32),
            .DEPTH       (DEPTH),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .req    (req[g]),
            .we     (we),
            .funct3 (funct3),
            .a      (a),
            .wd     (wd),
            .rd     (rdV[g]),
            .ready  (readyV[g]),
            .busy   (busyV[g]),
            .err    (errV[g])
        );
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
        end
    endtask

    // Reference: byte-addressed memory, sizes and offsets from funct3/address
    task automatic refAccess(input logic w, input logic [2:0] f, input logic [31:0] addr,
                             input logic [31:0] data, output logic [31:0] expRd, output logic expErr);
        int size;
        int off;
        int base;
        bit bad;
        logic [63:0] val;
        off  = int'(addr % 4);
        base = int'((addr / 4) % DEPTH) * 4;
        bad  = (f == 3'd3 || f == 3'd6 || f == 3'd7) || (w && (f == 3'd4 || f == 3'd5));
        size = (f % 4 == 0) ? 1 : ((f % 4 == 1) ? 2 : 4);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (off % size != 0) bad = 1'b1;
`else
        off = off - (off % size);
`endif
        expErr = bad;
        expRd  = 32'd0;
        if (!bad) begin
            if (w) begin
                for (int j = 0; j < size; j++) refMem[base + off + j] = 8'(data >> (8 * j));
            end else begin
                val = 64'd0;
                for (int j = 0; j < size; j++) val = val | (64'(refMem[base + off + j]) << (8 * j));
                if (f < 3'd4 && size < 4 && val[8*size-1]) val = val | ~((64'd1 << (8 * size)) - 64'd1);
                expRd = val[31:0];
            end
        end
    endtask

    // One transaction, started at a negedge; checks busy/ready per cycle
    // and rd/err on the ready cycle. noise re-raises req with garbage
    // operands while every selected instance is still busy.
    task automatic applyStimulus(input logic [NDUT-1:0] mask, input logic w, input logic [2:0] f,
                                 input logic [31:0] addr, input logic [31:0] data, input bit noise);
        logic [31:0] expRd;
        logic        expErr;
        int          ws;
        refAccess(w, f, addr, data, expRd, expErr);
        opNum++;
        req = mask; we = w; funct3 = f; a = addr; wd = data;
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0 && noise) begin
                req = mask; we = ~w; funct3 = 3'($urandom); a = $urandom; wd = $urandom;
            end else begin
                req = '0;
            end
            for (int i = 0; i < NDUT; i++) begin
                if (mask[i]) begin
                    ws = wsOf(i);
                    checkOutput($sformatf("op%0d dut%0d k%0d busy", opNum, i, k), 32'(busyV[i]), 32'(k <= ws));
                    checkOutput($sformatf("op%0d dut%0d k%0d ready", opNum, i, k), 32'(readyV[i]), 32'(k == ws));
                    if (k == ws) begin
                        checkOutput($sformatf("op%0d dut%0d rd", opNum, i), rdV[i], expRd);
                        checkOutput($sformatf("op%0d dut%0d err", opNum, i), 32'(errV[i]), 32'(expErr));
                    end
                end
            end
        end
    endtask

    initial begin
        logic [2:0] f;
        rst = 1'b1; req = '0; we = 1'b0; funct3 = '0; a = '0; wd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("reset dut%0d rd", i), rdV[i], 32'd0);
            checkOutput($sformatf("reset dut%0d ready", i), 32'(readyV[i]), 32'd0);
            checkOutput($sformatf("reset dut%0d busy", i), 32'(busyV[i]), 32'd0);
            checkOutput($sformatf("reset dut%0d err", i), 32'(errV[i]), 32'd0);
        end

        // fill the whole array so every later load is defined
        for (int w = 0; w < DEPTH; w++) applyStimulus(3'b111, 1'b1, F3_W, 32'(w * 4), $urandom, 1'b0);

        // word, byte and halfword stores/loads around word 0x4
        applyStimulus(3'b111, 1'b1, F3_W,  32'h4, 32'hABCDEF01, 1'b0);
        applyStimulus(3'b111, 1'b0, F3_W,  32'h4, 32'h0, 1'b1);
        applyStimulus(3'b111, 1'b1, F3_B,  32'h5, 32'h000000FF, 1'b0);
        applyStimulus(3'b111, 1'b0, F3_W,  32'h4, 32'h0, 1'b0);
        applyStimulus(3'b111, 1'b0, F3_B,  32'h5, 32'h0, 1'b0);
        applyStimulus(3'b111, 1'b0, F3_BU, 32'h5, 32'h0, 1'b0);
        applyStimulus(3'b111, 1'b1, F3_H,  32'h6, 32'h00008001, 1'b0);
        applyStimulus(3'b111, 1'b0, F3_W,  32'h4, 32'h0, 1'b0);
        applyStimulus(3'b111, 1'b0, F3_H,  32'h6, 32'h0, 1'b0);
        applyStimulus(3'b111, 1'b0, F3_HU, 32'h6, 32'h0, 1'b0);

        // misaligned accesses
        applyStimulus(3'b111, 1'b0, F3_W,  32'h6, 32'h0, 1'b0);
        applyStimulus(3'b111, 1'b1, F3_W,  32'h5, 32'h11111111, 1'b0);
        applyStimulus(3'b111, 1'b0, F3_W,  32'h4, 32'h0, 1'b0);

        // illegal codes, then address wrap
        applyStimulus(3'b111, 1'b1, 3'b011, 32'h4, 32'hDEADBEEF, 1'b0);
        applyStimulus(3'b111, 1'b1, F3_BU,  32'h4, 32'hDEADBEEF, 1'b0);
        applyStimulus(3'b111, 1'b0, F3_W,   32'h4, 32'h0, 1'b1);
        applyStimulus(3'b111, 1'b1, F3_W,   32'(DEPTH * 4 + 8), 32'h5A5A5A5A, 1'b1);
        applyStimulus(3'b111, 1'b0, F3_W,   32'h8, 32'h0, 1'b0);

        // reset during an access in flight (instances with wait states)
        applyStimulus(3'b111, 1'b1, F3_W, 32'h8, 32'h00000000, 1'b0);
        req = 3'b110; we = 1'b1; funct3 = F3_W; a = 32'h8; wd = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req = '0;
        rst = 1'b1;
        checkOutput("abort dut1 busy", 32'(busyV[1]), 32'd1);
        checkOutput("abort dut2 busy", 32'(busyV[2]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("abort dut%0d rd", i), rdV[i], 32'd0);
            checkOutput($sformatf("abort dut%0d busy", i), 32'(busyV[i]), 32'd0);
            checkOutput($sformatf("abort dut%0d err", i), 32'(errV[i]), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NDUT; i++) begin
                checkOutput($sformatf("abort dut%0d k%0d ready", i, k), 32'(readyV[i]), 32'd0);
            end
            @(negedge clk);
        end
        applyStimulus(3'b111, 1'b0, F3_W, 32'h8, 32'h0, 1'b0);

        // random mix over the full address range
        for (int n = 0; n < 60; n++) begin
            f = 3'($urandom_range(0, 7));
            applyStimulus(3'b111, 1'($urandom), f, $urandom, $urandom, ($urandom % 4) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised successor to the single-cycle data memory.
- Adds RISC-V sub-word access (LB/LH/LW/LBU/LHU, SB/SH/SW) with sign/zero extension and byte-lane writes.
- Adds a req/ready handshake with a configurable number of wait states, so the core can target multi-cycle memory.
- Sits between the execute stage and data storage; word-organised internal array.

Parameters:
- DATA_W, 32, data word width; fixed at 32 for RV32 lane logic.
- ADDR_W, 32, byte-address width.
- DEPTH, 64, number of 32-bit words; power of two.
- WAIT_STATES, 1, extra cycles between request acceptance and access (0 allowed).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request strobe, sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V size/sign code.
- a  in  ADDR_W  byte address.
- wd  in  DATA_W  store data, right-aligned.
- rd  out  DATA_W  load result, extended to 32 bits.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high from acceptance until ready.
- err  out  1  error flag, valid with ready.

Behaviour:
- Word index = a[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- FSM states: IDLE, WAIT, RESP.
- IDLE, req=1: latch a, we, wd and funct3; busy becomes 1. Next state is WAIT with counter = WAIT_STATES-1, or RESP directly if WAIT_STATES=0.
- WAIT: counter decrements each cycle; at 0, go to RESP.
- Array access (write, or read into the rd register) occurs on the clock edge entering RESP.
- RESP: ready=1 and rd/err valid for exactly one cycle; next state IDLE with busy=0.
- Latency: req accepted at edge N gives ready high in cycle N+1+WAIT_STATES. Throughput is one access per WAIT_STATES+2 cycles.
- req outside IDLE is ignored and not queued. Inputs are don't-care once latched.
- rd holds its last value until the next RESP. On a store, rd=0.
- funct3 decode:
  - 000 LB/SB: byte lane a[1:0].
  - 001 LH/SH: halfword lane a[1].
  - 010 LW/SW: full word.
  - 100 LBU and 101 LHU: zero-extended loads.
  - LB/LH sign-extend.
  - 100/101 with we=1, and 011/110/111 always: illegal → err=1, no write, rd=0.
- Stores modify only the selected byte lanes; all other bytes are preserved.
- Reset: state IDLE, counter 0, rd 0, ready 0, busy 0, err 0. Array contents are not reset.
- Reset mid-operation (WAIT or RESP entry edge) aborts the access: no write, no ready pulse.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: misaligned accesses (half with a[0]=1, word with a[1:0]≠0) are flagged. The response gives err=1 and rd=0, and no write occurs.
- Undefined: low address bits are forced to natural alignment (a[0] cleared for half, a[1:0] cleared for word). err reflects only illegal funct3.

Decomposition:
- Shared package dmem_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - FSM state typedef;
  - helper function for the sign-extend width.
- One natural combinational sub-module, dmem_ls_align:
  - inputs funct3, a[1:0], wd, raw read word;
  - outputs 4-bit byte-enable, lane-shifted write data, extended load data, misalign/illegal flags.

Test Plan:
- Reset, then SW a=0x4 wd=0xABCDEF01, then LW a=0x4 → rd=0xABCDEF01, err=0. ready at exactly N+1+WAIT_STATES for WAIT_STATES=0, 1 and 3; busy high throughout.
- SB a=0x5 wd=0x000000FF → LW 0x4 gives 0xABCDFF01. LB 0x5 gives 0xFFFFFFFF; LBU 0x5 gives 0x000000FF.
- SH a=0x6 wd=0x00008001 → LW 0x4 gives 0x8001FF01. LH 0x6 gives 0xFFFF8001; LHU 0x6 gives 0x00008001.
- Misaligned case:
  - With macro: LW 0x6 → err=1, rd=0; SW a=0x5 wd=0x11111111 leaves word 0x4 unchanged.
  - Without macro: LW 0x6 → rd=word at 0x4, err=0.
- Illegal and wrap cases:
  - funct3=011 store → err=1, no write.
  - SW at a=DEPTH*4+0x8 wd=0x5A5A5A5A → LW 0x8 returns 0x5A5A5A5A.
  - req pulsed while busy → ignored, exactly one ready.
- Abort case: SW 0x8 wd=0x00000000 completes, then SW 0x8 wd=0x12345678 with rst asserted in WAIT → no ready pulse; LW 0x8 after reset returns 0x00000000.
